// File: rtl/crp16_stage_sequencer.sv
// CRP16 multi-cycle stage sequencer: per-stage latch enables, fetch/data-port
// handshakes, debug halt/step/run, a stall watchdog and an instruction-retire counter.
module crp16_stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 2,
    parameter int IF_STAGE   = 0,
    parameter int EM_STAGE   = 2,
    parameter int MAX_WAIT   = 255,
    parameter int CNT_W      = 16,
    parameter int RESET_RUN  = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_em_need,
    input  logic                  i_if_ack,
    input  logic                  i_em_ack,
    input  logic                  i_halt_req,
    input  logic                  i_step,
    input  logic                  i_run,
    output logic [STAGE_W-1:0]    o_stage,
    output logic [NUM_STAGES-1:0] o_stage_en,
    output logic                  o_if_req,
    output logic                  o_em_req,
    output logic                  o_retire,
    output logic [CNT_W-1:0]      o_retire_count,
    output logic                  o_halted,
    output logic                  o_fault
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam bit WD_ON  = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WD_ON ? WAIT_W'(MAX_WAIT - 1) : '0;
    localparam logic [STAGE_W-1:0] LAST_IDX  = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] IF_IDX    = STAGE_W'(IF_STAGE);
    localparam logic [STAGE_W-1:0] EM_IDX    = STAGE_W'(EM_STAGE);

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_HALTED   = 2'd1,
        ST_STEPPING = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (RESET_RUN != 0) ? ST_ACTIVE : ST_HALTED;

    state_t                  r_state;
    logic [STAGE_W-1:0]      r_stage;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [CNT_W-1:0]        r_retire_count;

    logic                    w_active;
    logic                    w_at_if;
    logic                    w_at_em;
    logic                    w_if_req;
    logic                    w_em_req;
    logic                    w_ready;
    logic                    w_stall;
    logic                    w_expire;
    logic                    w_retire;
    logic [NUM_STAGES-1:0]   w_stage_en;

    // Handshake, ready and enable decode; held quiet while reset is asserted.
    always_comb begin
        w_active = !i_reset && ((r_state == ST_ACTIVE) || (r_state == ST_STEPPING));
        w_at_if  = (r_stage == IF_IDX);
        w_at_em  = (r_stage == EM_IDX);
        w_if_req = w_active && w_at_if;
        w_em_req = w_active && w_at_em && i_em_need;
        w_ready  = w_active && (!w_at_if || i_if_ack) && (!w_at_em || !i_em_need || i_em_ack);
        w_stall  = (w_if_req && !i_if_ack) || (w_em_req && !i_em_ack);
        w_expire = WD_ON && w_stall && (r_wait_cnt == WAIT_LAST);
        w_retire = w_ready && (r_stage == LAST_IDX);
        w_stage_en = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_stage_en[i] = w_ready && (r_stage == STAGE_W'(i));
        end
    end

    // Sequencer state, stage index, watchdog and retire counter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= RESET_STATE;
            r_stage        <= '0;
            r_wait_cnt     <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_ready) begin
                r_wait_cnt <= '0;
            end else if (WD_ON && w_stall && !w_expire) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end

            // The final stage wraps to 0, so a halt taken on retire lands on stage 0.
            if (w_ready) begin
                r_stage <= (r_stage == LAST_IDX) ? '0 : r_stage + STAGE_W'(1);
            end else begin
                r_stage <= r_stage;
            end

            if (w_retire) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end else begin
                r_retire_count <= r_retire_count;
            end

            case (r_state)
                ST_ACTIVE: begin
                    if (w_expire) begin
                        r_state <= ST_FAULT;
                    end else if (w_retire && i_halt_req) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_STEPPING: begin
                    if (w_expire) begin
                        r_state <= ST_FAULT;
                    end else if (w_retire) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_state <= ST_STEPPING;
                    end
                end
                ST_HALTED: begin
                    if (i_run) begin
                        r_state <= ST_ACTIVE;
                    end else if (i_step) begin
                        r_state <= ST_STEPPING;
                    end else begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign o_stage        = r_stage;
    assign o_stage_en     = w_stage_en;
    assign o_if_req       = w_if_req;
    assign o_em_req       = w_em_req;
    assign o_retire       = w_retire;
    assign o_retire_count = r_retire_count;
    assign o_halted       = (r_state == ST_HALTED);
    assign o_fault        = (r_state == ST_FAULT);

endmodule
